// File: rtl/viterbi_acs_array.sv
// Rate-1/2 Viterbi branch-metric and add-compare-select engine covering all 2^(K-1) trellis states.
// Define VITERBI_ACS_BEST_EN to register the lowest-index argmin state alongside every update.
module viterbi_acs_array #(
  parameter int unsigned  K  = 4,
  parameter logic [K-1:0] G0 = 4'b1111,
  parameter logic [K-1:0] G1 = 4'b1101,
  parameter int unsigned  SW = 1,
  parameter int unsigned  MW = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic                        frame_start,
  input  logic                        in_valid,
  input  logic [2*SW-1:0]             d_in,
  output logic                        out_valid,
  output logic [2**(K-1)-1:0]         survivor,
  output logic [2**(K-1)-1:0]         state_valid,
  output logic [(2**(K-1))*MW-1:0]    pm_flat,
  output logic                        norm_event,
  output logic [K-2:0]                best_state
);

  localparam int unsigned NS   = 2**(K-1);
  localparam logic [SW-1:0] SMAX = '1;

  logic [MW-1:0] pm_q      [NS];
  logic [MW-1:0] src_pm    [NS];
  logic [MW-1:0] new_pm    [NS];
  logic [NS-1:0] src_valid;
  logic [NS-1:0] new_valid;
  logic [NS-1:0] new_surv;
  logic [NS-1:0] msb_ok;
  logic          norm_c;

  // Soft-decision distance of one received pair to the branch labelled by encoder register r.
  function automatic logic [SW:0] branch_metric(input logic [K-1:0] r, input logic [2*SW-1:0] d);
    logic [SW-1:0] x0, x1, c0, c1;
    x0 = d[SW-1:0];
    x1 = d[2*SW-1:SW];
    c0 = (^(r & G0)) ? SMAX - x0 : x0;
    c1 = (^(r & G1)) ? SMAX - x1 : x1;
    return {1'b0, c0} + {1'b0, c1};
  endfunction

  // A frame restart replaces the registered metrics with the initial trellis state.
  assign src_valid = frame_start ? NS'(1) : state_valid;
  assign norm_c    = (|src_valid) & (&msb_ok);

  for (genvar s = 0; s < NS; s++) begin : g_acs
    localparam logic [K-2:0] NSB = (K-1)'(s);
    localparam logic [K-2:0] P0  = {NSB[K-3:0], 1'b0};
    localparam logic [K-2:0] P1  = {NSB[K-3:0], 1'b1};
    localparam logic [K-1:0] R0  = {NSB[K-2], P0};
    localparam logic [K-1:0] R1  = {NSB[K-2], P1};

    logic [MW:0]   sum0, sum1;
    logic [MW-1:0] c0, c1, sel_pm;
    logic          take1;

    assign src_pm[s] = frame_start ? '0 : pm_q[s];
    assign msb_ok[s] = ~src_valid[s] | src_pm[s][MW-1];

    assign sum0 = {1'b0, src_pm[P0]} + (MW+1)'(branch_metric(R0, d_in));
    assign sum1 = {1'b0, src_pm[P1]} + (MW+1)'(branch_metric(R1, d_in));
    assign c0   = sum0[MW] ? '1 : sum0[MW-1:0];
    assign c1   = sum1[MW] ? '1 : sum1[MW-1:0];

    // p1 only wins when p0 is unreachable or strictly worse, so ties go to p0.
    assign take1        = src_valid[P1] & (~src_valid[P0] | (c1 < c0));
    assign new_valid[s] = src_valid[P0] | src_valid[P1];
    assign new_surv[s]  = take1;
    assign sel_pm       = !new_valid[s] ? '0 : (take1 ? c1 : c0);
    assign new_pm[s]    = norm_c ? {1'b0, sel_pm[MW-2:0]} : sel_pm;

    assign pm_flat[s*MW +: MW] = pm_q[s];
  end

`ifdef VITERBI_ACS_BEST_EN
  logic [K-2:0]  best_c;
  logic [MW-1:0] best_pm;
  logic          found;

  // Strict less-than keeps the lowest index among equal metrics.
  always_comb begin
    best_c  = '0;
    best_pm = '0;
    found   = 1'b0;
    for (int unsigned s = 0; s < NS; s++) begin
      if (new_valid[s] && (!found || new_pm[s] < best_pm)) begin
        found   = 1'b1;
        best_pm = new_pm[s];
        best_c  = (K-1)'(s);
      end
    end
  end
`else
  assign best_state = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pm_q        <= '{default: '0};
      state_valid <= NS'(1);
      survivor    <= '0;
      out_valid   <= 1'b0;
      norm_event  <= 1'b0;
`ifdef VITERBI_ACS_BEST_EN
      best_state  <= '0;
`endif
    end else if (!enable) begin
      pm_q        <= '{default: '0};
      state_valid <= NS'(1);
      survivor    <= '0;
      out_valid   <= 1'b0;
      norm_event  <= 1'b0;
`ifdef VITERBI_ACS_BEST_EN
      best_state  <= '0;
`endif
    end else if (in_valid) begin
      pm_q        <= new_pm;
      state_valid <= new_valid;
      survivor    <= new_surv;
      out_valid   <= 1'b1;
      norm_event  <= norm_c;
`ifdef VITERBI_ACS_BEST_EN
      best_state  <= best_c;
`endif
    end else begin
      out_valid   <= 1'b0;
      norm_event  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_viterbi_acs_array.sv
// Scoreboard bench for viterbi_acs_array: a forward-trellis reference model predicts every update.
// Instance 0 is K=3 (7,5) hard decision with MW=5; instance 1 is K=4 with 3-bit soft symbols.
module tb_viterbi_acs_array;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        en0, fs0, iv0, ov0, ne0;
  logic [1:0]  d0, bs0;
  logic [3:0]  sv0, vl0;
  logic [19:0] pm0;

  logic        en1, fs1, iv1, ov1, ne1;
  logic [5:0]  d1;
  logic [2:0]  bs1;
  logic [7:0]  sv1, vl1;
  logic [71:0] pmf1;

  viterbi_acs_array #(.K(3), .G0(3'b111), .G1(3'b101), .SW(1), .MW(5)) dut0 (
    .clk(clk), .rst(rst), .enable(en0), .frame_start(fs0), .in_valid(iv0), .d_in(d0),
    .out_valid(ov0), .survivor(sv0), .state_valid(vl0), .pm_flat(pm0),
    .norm_event(ne0), .best_state(bs0));

  viterbi_acs_array #(.K(4), .G0(4'b1111), .G1(4'b1101), .SW(3), .MW(9)) dut1 (
    .clk(clk), .rst(rst), .enable(en1), .frame_start(fs1), .in_valid(iv1), .d_in(d1),
    .out_valid(ov1), .survivor(sv1), .state_valid(vl1), .pm_flat(pmf1),
    .norm_event(ne1), .best_state(bs1));

  typedef struct packed {
    logic [7:0]  surv;
    logic [7:0]  valid;
    logic [71:0] pmv;
    logic        norm;
    logic [2:0]  best;
    logic        chk_gold;
    logic [7:0]  gold_surv;
    logic        chk_true;
    logic [2:0]  true_st;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t em0, em1, discard;
  logic [3:0] tq[$];

  int errors = 0;
  int checks = 0;
  int norm_seen = 0;

  int ck[2]   = '{3, 4};
  int cg0[2]  = '{7, 15};
  int cg1[2]  = '{5, 13};
  int csw[2]  = '{1, 3};
  int cmw[2]  = '{5, 9};

  int mp[2][8];
  bit mv[2][8];
  int gp[8];
  bit gv[8];

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset(input int c);
    for (int s = 0; s < 8; s++) begin
      mp[c][s] = 0;
      mv[c][s] = (s == 0);
      if (c == 0) begin
        gp[s] = 0;
        gv[s] = (s == 0);
      end
    end
  endtask

  // Forward trellis expansion: every reachable state offers a branch for u=0 and u=1.
  task automatic acs(input int c, input bit raw, input int sp[8], input bit sv[8],
                     input int x0, input int x1, output int np[8], output bit nv[8],
                     output bit sel[8], output bit nrm);
    int n, smax, pmax, half, r, t, e0, e1, b, cd;
    bit any;
    n    = 1 << (ck[c] - 1);
    smax = (1 << csw[c]) - 1;
    pmax = (1 << cmw[c]) - 1;
    half = 1 << (cmw[c] - 1);
    for (int s = 0; s < 8; s++) begin
      np[s] = 0; nv[s] = 0; sel[s] = 0;
    end
    nrm = 0;
    if (!raw) begin
      nrm = 1; any = 0;
      for (int s = 0; s < n; s++)
        if (sv[s]) begin
          any = 1;
          if (sp[s] < half) nrm = 0;
        end
      nrm = nrm && any;
    end
    for (int p = 0; p < n; p++) begin
      if (sv[p]) begin
        for (int u = 0; u < 2; u++) begin
          r  = u * n + p;
          t  = (p >> 1) + u * (n / 2);
          e0 = $countones(r & cg0[c]) % 2;
          e1 = $countones(r & cg1[c]) % 2;
          b  = ((e0 != 0) ? smax - x0 : x0) + ((e1 != 0) ? smax - x1 : x1);
          cd = sp[p] + b;
          if (!raw && cd > pmax) cd = pmax;
          if (!nv[t] || cd < np[t]) begin
            nv[t] = 1; np[t] = cd; sel[t] = bit'(p % 2);
          end
        end
      end
    end
    if (nrm)
      for (int s = 0; s < n; s++)
        if (nv[s]) np[s] = np[s] - half;
  endtask

  task automatic model_step(input int c, input bit fs, input int x0, input int x1, output exp_t e);
    int sp[8], np[8];
    bit sv[8], nv[8], sel[8];
    bit nrm;
    int n, bi, bp;
    n = 1 << (ck[c] - 1);
    for (int s = 0; s < 8; s++) begin
      sp[s] = fs ? 0 : mp[c][s];
      sv[s] = fs ? (s == 0) : mv[c][s];
    end
    acs(c, 1'b0, sp, sv, x0, x1, np, nv, sel, nrm);
    e = '0; bi = 0; bp = -1;
    for (int s = 0; s < n; s++) begin
      mp[c][s]   = np[s];
      mv[c][s]   = nv[s];
      e.surv[s]  = sel[s];
      e.valid[s] = nv[s];
      e.pmv      = e.pmv | (72'(np[s]) << (s * cmw[c]));
      if (nv[s] && (bp < 0 || np[s] < bp)) begin
        bp = np[s]; bi = s;
      end
    end
    e.norm = nrm;
    e.best = 3'(bi);
  endtask

  // Issue one symbol, push its expected update, and return #1 after the capturing edge.
  task automatic send(input int c, input bit fs, input int x0, input int x1,
                      input bit ct, input int ts, input bit cg);
    exp_t e;
    int sp[8], np[8];
    bit sv[8], nv[8], sel[8];
    bit nrm;
    model_step(c, fs, x0, x1, e);
    e.chk_true = ct;
    e.true_st  = 3'(ts);
    if (c == 0) begin
      for (int s = 0; s < 8; s++) begin
        sp[s] = fs ? 0 : gp[s];
        sv[s] = fs ? (s == 0) : gv[s];
      end
      acs(0, 1'b1, sp, sv, x0, x1, np, nv, sel, nrm);
      for (int s = 0; s < 8; s++) begin
        gp[s] = np[s]; gv[s] = nv[s]; e.gold_surv[s] = sel[s];
      end
      e.chk_gold = cg;
      q0.push_back(e);
      fs0 = fs; iv0 = 1'b1; d0 = {x1[0], x0[0]};
    end else begin
      q1.push_back(e);
      fs1 = fs; iv1 = 1'b1; d1 = {3'(x1), 3'(x0)};
    end
    @(posedge clk); #1;
    iv0 = 1'b0; iv1 = 1'b0; fs0 = 1'b0; fs1 = 1'b0;
  endtask

  task automatic chk_rst0();
    chk("rst0_out_valid", 72'(ov0), 72'(0));
    chk("rst0_state_valid", 72'(vl0), 72'(1));
    chk("rst0_pm", 72'(pm0), 72'(0));
    chk("rst0_survivor", 72'(sv0), 72'(0));
    chk("rst0_norm", 72'(ne0), 72'(0));
    chk("rst0_best", 72'(bs0), 72'(0));
  endtask

  task automatic chk_rst1();
    chk("rst1_out_valid", 72'(ov1), 72'(0));
    chk("rst1_state_valid", 72'(vl1), 72'(1));
    chk("rst1_pm", pmf1, 72'(0));
    chk("rst1_survivor", 72'(sv1), 72'(0));
  endtask

  task automatic check_t1();
    chk("t1_out_valid", 72'(ov0), 72'(1));
    chk("t1_state_valid", 72'(vl0), 72'(4'b0101));
    chk("t1_pm0", 72'(pm0[4:0]), 72'(0));
    chk("t1_pm2", 72'(pm0[14:10]), 72'(2));
    chk("t1_survivor", 72'(sv0), 72'(0));
  endtask

  function automatic int pick_x();
    if ($urandom_range(0, 1) == 1) return ($urandom_range(0, 1) == 1) ? 7 : 0;
    return int'($urandom_range(0, 7));
  endfunction

  // Monitor for instance 0.
  always @(negedge clk) begin
    if (ov0) begin
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_out0: out_valid=1 with no pending expectation");
      end else begin
        em0 = q0.pop_front();
        chk("surv0", 72'(sv0), 72'(em0.surv[3:0]));
        chk("valid0", 72'(vl0), 72'(em0.valid[3:0]));
        chk("pm0", 72'(pm0), em0.pmv);
        chk("norm0", 72'(ne0), 72'(em0.norm));
`ifdef VITERBI_ACS_BEST_EN
        chk("best0", 72'(bs0), 72'(em0.best[1:0]));
`else
        chk("best0_tied", 72'(bs0), 72'(0));
`endif
        if (em0.chk_gold) begin
          chk("gold_surv0", 72'(sv0), 72'(em0.gold_surv[3:0]));
          if (ne0) norm_seen++;
        end
        if (em0.chk_true) begin
          tq.push_back(sv0);
          for (int s = 0; s < 4; s++) begin
            if (s == int'(em0.true_st)) chk("true_path_pm", 72'((pm0 >> (s * 5)) & 20'h1f), 72'(0));
            else if (vl0[s]) chk("offpath_pm_ge1", 72'(((pm0 >> (s * 5)) & 20'h1f) >= 20'd1), 72'(1));
          end
        end
      end
    end
  end

  // Monitor for instance 1.
  always @(negedge clk) begin
    if (ov1) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_out1: out_valid=1 with no pending expectation");
      end else begin
        em1 = q1.pop_front();
        chk("surv1", 72'(sv1), 72'(em1.surv));
        chk("valid1", 72'(vl1), 72'(em1.valid));
        chk("pm1", pmf1, em1.pmv);
        chk("norm1", 72'(ne1), 72'(em1.norm));
`ifdef VITERBI_ACS_BEST_EN
        chk("best1", 72'(bs1), 72'(em1.best));
`else
        chk("best1_tied", 72'(bs1), 72'(0));
`endif
      end
    end
  end

  initial begin
    int tv[6];
    int st, u, e0, e1, s;
    logic [5:0] dec, expv;

    rst = 1'b1; en0 = 1'b1; en1 = 1'b1; iv0 = 1'b0; iv1 = 1'b0;
    fs0 = 1'b0; fs1 = 1'b0; d0 = '0; d1 = '0;
    model_reset(0); model_reset(1);
    repeat (2) @(posedge clk);
    #1;
    chk_rst0(); chk_rst1();
    rst = 1'b0;
    @(posedge clk); #1;

    // First symbol after reset with frame_start.
    send(0, 1'b1, 0, 0, 1'b0, 0, 1'b0);
    check_t1();

    // Error-free encoded stream, followed by traceback.
    tv = '{1, 0, 1, 1, 0, 0};
    tq.delete();
    st = 0;
    for (int t = 0; t < 6; t++) begin
      u  = tv[t];
      e0 = $countones((u * 4 + st) & 7) % 2;
      e1 = $countones((u * 4 + st) & 5) % 2;
      st = (st >> 1) + u * 2;
      send(0, t == 0, e0, e1, 1'b1, st, 1'b0);
    end
    @(negedge clk); #1;
    chk("traceback_len", 72'(tq.size()), 72'(6));
    if (tq.size() == 6) begin
      s = 0; dec = '0; expv = '0;
      for (int t = 5; t >= 0; t--) begin
        dec[t]  = (s >= 2);
        expv[t] = tv[t][0];
        s = ((s << 1) & 3) | int'(tq[t][s]);
      end
      chk("traceback_bits", 72'(dec), 72'(expv));
      chk("traceback_origin", 72'(s), 72'(0));
    end
    @(posedge clk); #1;

    // Continuous 11 stream drives all metrics upward until normalisation.
    norm_seen = 0;
    for (int t = 0; t < 100; t++) send(0, t == 0, 1, 1, 1'b0, 0, 1'b1);
    @(negedge clk); #1;
    chk("norm_observed", 72'(norm_seen > 0), 72'(1));
    @(posedge clk); #1;

    // Synchronous clear via enable mid-stream.
    repeat (5) send(0, 1'b0, int'($urandom_range(0, 1)), int'($urandom_range(0, 1)), 1'b0, 0, 1'b0);
    en0 = 1'b0; iv0 = 1'b1; d0 = 2'(int'($urandom_range(0, 3)));
    @(posedge clk); #1;
    en0 = 1'b1; iv0 = 1'b0;
    model_reset(0);
    chk_rst0();
    send(0, 1'b0, 0, 0, 1'b0, 0, 1'b0);
    check_t1();

    // Asynchronous reset between edges while an update is presented.
    repeat (5) send(0, 1'b0, int'($urandom_range(0, 1)), int'($urandom_range(0, 1)), 1'b0, 0, 1'b0);
    #1 rst = 1'b1;
    discard = q0.pop_back();
    model_reset(0); model_reset(1);
    #1;
    chk_rst0(); chk_rst1();
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    send(0, 1'b0, 0, 0, 1'b0, 0, 1'b0);
    check_t1();

    // Random hard-decision traffic with restarts and idle gaps.
    for (int t = 0; t < 150; t++) begin
      if ($urandom_range(0, 7) == 0) begin
        @(posedge clk); #1;
      end else begin
        send(0, $urandom_range(0, 15) == 0, int'($urandom_range(0, 1)),
             int'($urandom_range(0, 1)), 1'b0, 0, 1'b0);
      end
    end

    // Random soft symbols, biased toward extreme values so metric ties are common.
    for (int t = 0; t < 250; t++) begin
      if ($urandom_range(0, 7) == 0) begin
        @(posedge clk); #1;
      end else begin
        send(1, (t == 0) || ($urandom_range(0, 24) == 0), pick_x(), pick_x(), 1'b0, 0, 1'b0);
      end
    end

    for (int i = 0; i < 20 && (q0.size() != 0 || q1.size() != 0); i++) @(posedge clk);
    @(negedge clk); #1;
    chk("queues_drained", 72'(q0.size() + q1.size()), 72'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
